// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: parametrised UART receiver feeding a small receive FIFO.
// Reports framing errors and overruns as one-cycle pulses.
// Optional even-parity checking is compiled in by defining UART_RX_PARITY_EN.
module uart_rx_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned BAUD_DIV   = 2604,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        RX,
    input  logic                        clr_rdy,
    output logic [DATA_BITS-1:0]        cmd,
    output logic                        rdy,
    output logic                        frame_err,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_cnt
`ifdef UART_RX_PARITY_EN
    ,
    output logic                        parity_err
`endif
);

    localparam int unsigned CNT_W = $clog2(BAUD_DIV);
    localparam int unsigned IDX_W = $clog2(DATA_BITS);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned OCC_W = PTR_W + 1;

    // Counter counts down to zero, so a reload of N-1 gives an N-cycle interval.
    localparam logic [CNT_W-1:0] FULL_RELOAD = CNT_W'(BAUD_DIV - 1);
    localparam logic [CNT_W-1:0] HALF_RELOAD = CNT_W'(BAUD_DIV / 2 - 1);
    localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(DATA_BITS - 1);
    localparam logic [OCC_W-1:0] DEPTH_OCC   = OCC_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef UART_RX_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    logic                 rx_meta;
    logic                 rxs;
    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [DATA_BITS-1:0] sh_q, sh_d;
    logic                 expire_c;
    logic                 push_c;
    logic                 ferr_c;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d;
    logic                 perr_c;
`endif

    logic [DATA_BITS-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0]     occ_d;
    logic [DATA_BITS-1:0] head_d;
    logic                 full_c;
    logic                 pop_c;
    logic                 wr_c;
    logic                 ovf_c;

    // Two-flop synchroniser for the asynchronous serial input; idles high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= RX;
            rxs     <= rx_meta;
        end
    end

    assign expire_c = (cnt_q == '0);

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            sh_q    <= '0;
`ifdef UART_RX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            sh_q    <= sh_d;
`ifdef UART_RX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    // Receiver next-state logic: mid-bit sampling, shift-in, and stop-bit verdict.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sh_d    = sh_q;
        push_c  = 1'b0;
        ferr_c  = 1'b0;
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_c  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (!rxs) begin
                    state_d = ST_START;
                    cnt_d   = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (expire_c) begin
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        cnt_d   = FULL_RELOAD;
                        idx_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_DATA: begin
                if (expire_c) begin
                    sh_d  = {rxs, sh_q[DATA_BITS-1:1]};
                    cnt_d = FULL_RELOAD;
                    if (idx_q == LAST_IDX) begin
`ifdef UART_RX_PARITY_EN
                        state_d = ST_PARITY;
`else
                        state_d = ST_STOP;
`endif
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`ifdef UART_RX_PARITY_EN
            ST_PARITY: begin
                if (expire_c) begin
                    par_d   = rxs;
                    cnt_d   = FULL_RELOAD;
                    state_d = ST_STOP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
`endif
            ST_STOP: begin
                // Return to IDLE mid-stop-bit so a back-to-back start edge is caught.
                if (expire_c) begin
                    state_d = ST_IDLE;
                    ferr_c  = ~rxs;
`ifdef UART_RX_PARITY_EN
                    perr_c  = ^{sh_q, par_q};
                    push_c  = rxs & ~perr_c;
`else
                    push_c  = rxs;
`endif
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FIFO control: push/pop arbitration and the next head-of-queue word.
    always_comb begin
        full_c   = (fifo_cnt == DEPTH_OCC);
        pop_c    = clr_rdy & rdy;
        wr_c     = push_c & (~full_c | pop_c);
        ovf_c    = push_c & full_c & ~pop_c;
        wr_ptr_d = wr_ptr_q + PTR_W'(wr_c);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop_c);
        occ_d    = fifo_cnt + OCC_W'(wr_c) - OCC_W'(pop_c);
        head_d   = '0;
        if (occ_d != '0) begin
            // The incoming word bypasses storage when it becomes the new head.
            if (wr_c && (wr_ptr_q == rd_ptr_d)) begin
                head_d = sh_q;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    // FIFO storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_c) begin
            mem_q[wr_ptr_q] <= sh_q;
        end
    end

    // FIFO pointers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            fifo_cnt   <= '0;
            rdy        <= 1'b0;
            cmd        <= '0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            fifo_cnt   <= occ_d;
            rdy        <= (occ_d != '0);
            cmd        <= head_d;
            frame_err  <= ferr_c;
            overrun    <= ovf_c;
`ifdef UART_RX_PARITY_EN
            parity_err <= perr_c;
`endif
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Testbench for uart_rx_fifo: table-driven directed frames, hand-written corner
// sequences and randomised frames checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_uart_rx_fifo;

    localparam int unsigned DB = 8;
    localparam int unsigned BD = 16;
    localparam int unsigned FD = 4;
`ifdef UART_RX_PARITY_EN
    localparam int unsigned PB = 1;
`else
    localparam int unsigned PB = 0;
`endif
    // Stop-bit sample edge, counted in clocks from the start-bit falling edge:
    // mid-stop-bit plus two synchroniser flops and the IDLE detection cycle.
    localparam int unsigned STOP_EDGE = (1 + DB + PB) * BD + BD / 2 + 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          RX = 1'b1;
    logic          clr_rdy = 1'b0;
    logic [DB-1:0] cmd;
    logic          rdy;
    logic          frame_err;
    logic          overrun;
    logic [2:0]    fifo_cnt;
`ifdef UART_RX_PARITY_EN
    logic          parity_err;
`endif

    uart_rx_fifo #(.DATA_BITS(DB), .BAUD_DIV(BD), .FIFO_DEPTH(FD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .RX        (RX),
        .clr_rdy   (clr_rdy),
        .cmd       (cmd),
        .rdy       (rdy),
        .frame_err (frame_err),
        .overrun   (overrun),
        .fifo_cnt  (fifo_cnt)
`ifdef UART_RX_PARITY_EN
        ,
        .parity_err(parity_err)
`endif
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int fe_seen = 0, ov_seen = 0, pe_seen = 0;
    int exp_fe = 0, exp_ov = 0, exp_pe = 0;
    logic [DB-1:0] mq[$];

    typedef struct {
        logic [DB-1:0] data;
        logic          stop;
        int            exp_cnt;
        logic [DB-1:0] exp_head;
        int            exp_fe;
        int            exp_ov;
    } vec_t;
    vec_t tbl[7];

    // Count flag pulses; a stuck flag shows up as an excess count.
    always @(negedge clk) begin
        if (rst_n) begin
            if (frame_err) fe_seen++;
            if (overrun) ov_seen++;
`ifdef UART_RX_PARITY_EN
            if (parity_err) pe_seen++;
`endif
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Reference model: frame-level outcome from stop bit, parity and occupancy.
    task automatic model_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_flip);
        if (!stop_bit || par_flip) begin
            if (!stop_bit) exp_fe++;
            if (par_flip) exp_pe++;
        end else if (mq.size() < FD) begin
            mq.push_back(d);
        end else begin
            exp_ov++;
        end
    endtask

    // Drive one frame; called and returns on a falling clock edge.
    task automatic send_frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_flip);
        RX = 1'b0;
        repeat (BD) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            RX = d[i];
            repeat (BD) @(negedge clk);
        end
`ifdef UART_RX_PARITY_EN
        RX = (^d) ^ par_flip;
        repeat (BD) @(negedge clk);
`endif
        RX = stop_bit;
        repeat (BD) @(negedge clk);
        RX = 1'b1;
    endtask

    task automatic frame(input logic [DB-1:0] d, input logic stop_bit, input logic par_flip);
        send_frame(d, stop_bit, par_flip);
        model_frame(d, stop_bit, par_flip);
        repeat (2) @(negedge clk);
    endtask

    task automatic check_state(input string tag);
        check({tag, " fifo_cnt"}, 32'(fifo_cnt), 32'(mq.size()));
        check({tag, " rdy"}, 32'(rdy), 32'(mq.size() != 0));
        if (mq.size() != 0) check({tag, " cmd"}, 32'(cmd), 32'(mq[0]));
        check({tag, " frame_err pulses"}, fe_seen, exp_fe);
        check({tag, " overrun pulses"}, ov_seen, exp_ov);
`ifdef UART_RX_PARITY_EN
        check({tag, " parity_err pulses"}, pe_seen, exp_pe);
`endif
    endtask

    task automatic pop_one(input string tag);
        check({tag, " pop rdy"}, 32'(rdy), 32'd1);
        check({tag, " pop cmd"}, 32'(cmd), 32'(mq[0]));
        clr_rdy = 1'b1;
        @(negedge clk);
        clr_rdy = 1'b0;
        void'(mq.pop_front());
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " rdy"}, 32'(rdy), 32'd0);
        check({tag, " fifo_cnt"}, 32'(fifo_cnt), 32'd0);
        check({tag, " cmd"}, 32'(cmd), 32'd0);
        check({tag, " frame_err"}, 32'(frame_err), 32'd0);
        check({tag, " overrun"}, 32'(overrun), 32'd0);
    endtask

    initial begin
        int rise;
        int fe_base, ov_base;
        logic [DB-1:0] rd;
        logic rs;

        tbl[0] = '{8'hA5, 1'b1, 1, 8'hA5, 0, 0};
        tbl[1] = '{8'h33, 1'b0, 1, 8'hA5, 1, 0};
        tbl[2] = '{8'h44, 1'b1, 2, 8'hA5, 1, 0};
        tbl[3] = '{8'h01, 1'b1, 3, 8'hA5, 1, 0};
        tbl[4] = '{8'h80, 1'b1, 4, 8'hA5, 1, 0};
        tbl[5] = '{8'hFF, 1'b1, 4, 8'hA5, 1, 1};
        tbl[6] = '{8'h3C, 1'b0, 4, 8'hA5, 2, 1};

        // Reset values.
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (4) @(negedge clk);

        // Single word: rdy must rise during the stop bit.
        rise = -1;
        fork
            send_frame(8'hA5, 1'b1, 1'b0);
            for (int c = 1; c <= STOP_EDGE + 40; c++) begin
                @(negedge clk);
                if (rdy && rise < 0) rise = c;
            end
        join
        model_frame(8'hA5, 1'b1, 1'b0);
        check("single rdy rise in stop bit", 32'((rise >= int'((1 + DB + PB) * BD)) &&
              (rise < int'((2 + DB + PB) * BD))), 32'd1);
        check_state("single");
        pop_one("single");
        check("single rdy after pop", 32'(rdy), 32'd0);
        check("single cnt after pop", 32'(fifo_cnt), 32'd0);

        // False start: a 5-cycle low glitch is rejected.
        RX = 1'b0;
        repeat (5) @(negedge clk);
        RX = 1'b1;
        repeat (3 * BD) @(negedge clk);
        check_state("false start");
        frame(8'h5A, 1'b1, 1'b0);
        check_state("after false start");
        pop_one("after false start");

        // Table-driven frames from an empty FIFO.
        fe_base = fe_seen;
        ov_base = ov_seen;
        for (int i = 0; i < 7; i++) begin
            frame(tbl[i].data, tbl[i].stop, 1'b0);
            check($sformatf("tbl%0d fifo_cnt", i), 32'(fifo_cnt), 32'(tbl[i].exp_cnt));
            check($sformatf("tbl%0d cmd", i), 32'(cmd), 32'(tbl[i].exp_head));
            check($sformatf("tbl%0d frame_err", i), fe_seen - fe_base, tbl[i].exp_fe);
            check($sformatf("tbl%0d overrun", i), ov_seen - ov_base, tbl[i].exp_ov);
        end
        while (mq.size() != 0) pop_one("tbl drain");
        check_state("tbl drained");

        // Back-to-back frames with no idle gap.
        send_frame(8'h01, 1'b1, 1'b0);
        send_frame(8'h80, 1'b1, 1'b0);
        send_frame(8'hFF, 1'b1, 1'b0);
        send_frame(8'h3C, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        model_frame(8'h01, 1'b1, 1'b0);
        model_frame(8'h80, 1'b1, 1'b0);
        model_frame(8'hFF, 1'b1, 1'b0);
        model_frame(8'h3C, 1'b1, 1'b0);
        check("b2b fifo_cnt", 32'(fifo_cnt), 32'd4);
        check_state("b2b");
        while (mq.size() != 0) pop_one("b2b drain");

        // Overrun, then a push coinciding with a pop while full.
        frame(8'h11, 1'b1, 1'b0);
        frame(8'h22, 1'b1, 1'b0);
        frame(8'h33, 1'b1, 1'b0);
        frame(8'h44, 1'b1, 1'b0);
        frame(8'h55, 1'b1, 1'b0);
        check_state("overrun");
        fork
            send_frame(8'h66, 1'b1, 1'b0);
            begin
                repeat (STOP_EDGE - 1) @(negedge clk);
                clr_rdy = 1'b1;
                @(negedge clk);
                clr_rdy = 1'b0;
            end
        join
        void'(mq.pop_front());
        model_frame(8'h66, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        check("coincident fifo_cnt", 32'(fifo_cnt), 32'd4);
        check_state("coincident");
        while (mq.size() != 0) pop_one("coincident drain");

`ifdef UART_RX_PARITY_EN
        // Parity: good parity accepted, bad parity discarded.
        frame(8'h41, 1'b1, 1'b0);
        check_state("parity good");
        frame(8'h41, 1'b1, 1'b1);
        check_state("parity bad");
        frame(8'h42, 1'b0, 1'b1);
        check_state("parity and frame bad");
        while (mq.size() != 0) pop_one("parity drain");
`endif

        // Randomised frames with random pops between them.
        for (int n = 0; n < 30; n++) begin
            int npop;
            npop = $urandom_range(0, mq.size());
            for (int k = 0; k < npop; k++) pop_one("rand");
            rd = DB'($urandom);
            rs = ($urandom_range(0, 7) != 0);
            frame(rd, rs, 1'b0);
            check_state($sformatf("rand%0d", n));
        end

        // Reset mid-DATA with words buffered.
        if (mq.size() == 0) begin
            frame(8'h77, 1'b1, 1'b0);
        end
        RX = 1'b0;
        repeat (3 * BD) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid-frame reset");
        RX = 1'b1;
        mq.delete();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat ((DB + 3) * BD) @(negedge clk);
        check_state("after reset");
        frame(8'h96, 1'b1, 1'b0);
        check_state("post-reset frame");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
